// File: rtl/data_mem_responder_pkg.sv
// Shared codes for the data-side memory responder: access types, MMIO offsets, error bits.
package data_mem_responder_pkg;
  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  localparam logic [7:0] OFF_GPIO       = 8'h00;
  localparam logic [7:0] OFF_CYCLE      = 8'h04;
  localparam logic [7:0] OFF_STORE_CNT  = 8'h08;
  localparam logic [7:0] OFF_ERR_STATUS = 8'h0C;
  localparam logic [7:0] OFF_ERR_ADDR   = 8'h10;

  localparam int ERR_MIS = 0;
  localparam int ERR_OOR = 1;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  // Undefined RW_type codes fall through to a word access.
  function automatic acc_size_e size_of(input logic [2:0] rw);
    case (rw)
      RW_B, RW_BU: return SZ_B;
      RW_H, RW_HU: return SZ_H;
      RW_W:        return SZ_W;
      default:     return SZ_W;
    endcase
  endfunction
endpackage

// File: rtl/data_mem_responder_data_ram.sv
// Word-organised RAM with per-byte write enables and a combinational read port.
module data_ram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output logic [31:0]           rdata_o
);
  logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++)
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/data_mem_responder.sv
// Load/store target for the single-cycle core: RAM, MMIO registers, sticky error tracking.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ram_addr,
  input  logic        R_en,
  input  logic        W_en,
  input  logic [2:0]  RW_type,
  input  logic [31:0] Wr_mem_data,
  output logic [31:0] Rd_mem_data,
  output logic [7:0]  gpio_out,
  output logic        mem_err
);
  acc_size_e   size;
  logic        acc, is_mmio, is_ram, oor, misal, ok;
  logic        ram_we, mmio_we;
  logic [3:0]  be;
  logic [31:0] wdata, ram_rdata, ld_word, ram_ld, mmio_rd;
  logic [1:0]  err_set, err_clr, err_kept;

  logic [7:0]  gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d, store_cnt_q, store_cnt_d, err_addr_q, err_addr_d;
  logic [1:0]  err_status_q, err_status_d;

  assign size    = size_of(RW_type);
  assign acc     = R_en | W_en;
  assign is_mmio = ram_addr[31:8] == MMIO_BASE[31:8];
  assign is_ram  = ram_addr[31:DEPTH_LOG2+2] == '0;
  assign oor     = !is_mmio && !is_ram;
  // MMIO registers only accept aligned word accesses.
  assign misal   = (size == SZ_H && ram_addr[0]) ||
                   (size == SZ_W && ram_addr[1:0] != 2'b00) ||
                   (is_mmio && size != SZ_W);
  assign ok      = !misal && !oor;

  // Reset low at the edge discards an in-flight store.
  assign ram_we  = W_en && is_ram && ok && rst_n;
  assign mmio_we = W_en && is_mmio && ok;

  always_comb begin
    be    = 4'b1111;
    wdata = Wr_mem_data;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << ram_addr[1:0];
        wdata = {4{Wr_mem_data[7:0]}};
      end
      SZ_H: begin
        be    = ram_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{Wr_mem_data[15:0]}};
      end
      default: ;
    endcase
  end

  data_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (be),
    .waddr_i (ram_addr[DEPTH_LOG2+1:2]),
    .wdata_i (wdata),
    .raddr_i (ram_addr[DEPTH_LOG2+1:2]),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    ld_word = ram_rdata >> {ram_addr[1:0], 3'b000};
    case (RW_type)
      RW_B:    ram_ld = {{24{ld_word[7]}}, ld_word[7:0]};
      RW_BU:   ram_ld = {24'b0, ld_word[7:0]};
      RW_H:    ram_ld = {{16{ld_word[15]}}, ld_word[15:0]};
      RW_HU:   ram_ld = {16'b0, ld_word[15:0]};
      default: ram_ld = ld_word;
    endcase
  end

  always_comb begin
    case (ram_addr[7:0])
      OFF_GPIO:       mmio_rd = {24'b0, gpio_q};
      OFF_CYCLE:      mmio_rd = cycle_q;
      OFF_STORE_CNT:  mmio_rd = store_cnt_q;
      OFF_ERR_STATUS: mmio_rd = {30'b0, err_status_q};
      OFF_ERR_ADDR:   mmio_rd = err_addr_q;
      default:        mmio_rd = '0;
    endcase
  end

  assign Rd_mem_data = (R_en && ok) ? (is_mmio ? mmio_rd : ram_ld) : '0;

  always_comb begin
    err_set          = '0;
    err_set[ERR_MIS] = acc && misal;
    err_set[ERR_OOR] = acc && oor;
    err_clr          = (mmio_we && ram_addr[7:0] == OFF_ERR_STATUS) ? Wr_mem_data[1:0] : 2'b00;
    err_kept         = err_status_q & ~err_clr;
    err_status_d     = err_kept | err_set;
    // Capture only when this error starts a fresh episode (status empty after clears).
    err_addr_d       = (err_kept == 2'b00 && err_set != 2'b00) ? ram_addr : err_addr_q;
    gpio_d           = (mmio_we && ram_addr[7:0] == OFF_GPIO) ? Wr_mem_data[7:0] : gpio_q;
    cycle_d          = cycle_q + 32'd1;
    store_cnt_d      = ram_we ? store_cnt_q + 32'd1 : store_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpio_q       <= '0;
      cycle_q      <= '0;
      store_cnt_q  <= '0;
      err_status_q <= '0;
      err_addr_q   <= '0;
    end else begin
      gpio_q       <= gpio_d;
      cycle_q      <= cycle_d;
      store_cnt_q  <= store_cnt_d;
      err_status_q <= err_status_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign gpio_out = gpio_q;
  assign mem_err  = |err_status_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte-level reference model checked every cycle.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ram_addr = '0;
  logic        R_en = 1'b0;
  logic        W_en = 1'b0;
  logic [2:0]  RW_type = 3'b010;
  logic [31:0] Wr_mem_data = '0;
  logic [31:0] Rd_mem_data;
  logic [7:0]  gpio_out;
  logic        mem_err;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] MB = 32'hFFFF_FF00;

  data_mem_responder dut (
    .clk(clk), .rst_n(rst_n), .ram_addr(ram_addr), .R_en(R_en), .W_en(W_en),
    .RW_type(RW_type), .Wr_mem_data(Wr_mem_data), .Rd_mem_data(Rd_mem_data),
    .gpio_out(gpio_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_mem [0:1023];
  bit          m_vld [0:1023];
  logic [7:0]  m_gpio = '0;
  logic [31:0] m_cycle = '0, m_scnt = '0, m_eaddr = '0;
  logic [1:0]  m_est = '0;

  function automatic int sz_bytes(input logic [2:0] t);
    if (t == 3'd0 || t == 3'd4) return 1;
    if (t == 3'd1 || t == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return a[31:8] == MB[31:8];
  endfunction

  function automatic bit is_bad_align(input logic [31:0] a, input logic [2:0] t);
    int s;
    s = sz_bytes(t);
    return (int'(a[1:0]) % s != 0) || (in_mmio(a) && s != 4);
  endfunction

  function automatic void model_rd(input logic [31:0] a, input logic [2:0] t, input logic r,
                                   output logic [31:0] v, output bit known);
    int s;
    s = sz_bytes(t);
    v = '0;
    known = 1'b1;
    if (!r || (!in_mmio(a) && a >= 32'd1024) || is_bad_align(a, t)) return;
    if (in_mmio(a)) begin
      case (a[7:0])
        8'h00: v = {24'b0, m_gpio};
        8'h04: v = m_cycle;
        8'h08: v = m_scnt;
        8'h0C: v = {30'b0, m_est};
        8'h10: v = m_eaddr;
        default: v = '0;
      endcase
      return;
    end
    for (int i = 0; i < s; i++) begin
      if (!m_vld[int'(a[9:0]) + i]) known = 1'b0;
      v = v | (32'(m_mem[int'(a[9:0]) + i]) << (8 * i));
    end
    if (t == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
  endfunction

  task automatic model_reset();
    m_gpio = '0; m_cycle = '0; m_scnt = '0; m_eaddr = '0; m_est = '0;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    logic [1:0] set, clr, kept;
    bit oor, bad;
    if (!rst_n) model_reset();
    else begin
      m_cycle = m_cycle + 32'd1;
      oor = !in_mmio(ram_addr) && ram_addr >= 32'd1024;
      bad = is_bad_align(ram_addr, RW_type);
      set = (R_en || W_en) ? {oor, bad} : 2'b00;
      clr = 2'b00;
      if (W_en && !oor && !bad) begin
        if (!in_mmio(ram_addr)) begin
          for (int i = 0; i < sz_bytes(RW_type); i++) begin
            m_mem[int'(ram_addr[9:0]) + i] = Wr_mem_data[8*i +: 8];
            m_vld[int'(ram_addr[9:0]) + i] = 1'b1;
          end
          m_scnt = m_scnt + 32'd1;
        end else if (ram_addr[7:0] == 8'h00) m_gpio = Wr_mem_data[7:0];
        else if (ram_addr[7:0] == 8'h0C) clr = Wr_mem_data[1:0];
      end
      kept = m_est & ~clr;
      if (kept == 2'b00 && set != 2'b00) m_eaddr = ram_addr;
      m_est = kept | set;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Model comparison on every falling edge
  always @(negedge clk) begin
    logic [31:0] ev;
    bit kn;
    model_rd(ram_addr, RW_type, R_en, ev, kn);
    if (kn) chk("model_rd", Rd_mem_data, ev);
    chk("model_gpio", {24'b0, gpio_out}, {24'b0, m_gpio});
    chk("model_err", {31'b0, mem_err}, {31'b0, m_est != 2'b00});
  end

  task automatic op(input logic r, input logic w, input logic [2:0] t,
                    input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    R_en = r; W_en = w; RW_type = t; ram_addr = a; Wr_mem_data = d;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_gpio", {24'b0, gpio_out}, 32'h0);
    chk("rst_err", {31'b0, mem_err}, 32'h0);
    chk("rst_rd_idle", Rd_mem_data, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1; R_en = 1'b1; RW_type = 3'b010; ram_addr = MB + 32'h04;
    @(negedge clk);
    chk("cycle_10", Rd_mem_data, 32'd10);
    op(1, 0, 3'b010, MB + 32'h08, 0); chk("scnt_rst", Rd_mem_data, 32'h0);
    op(1, 0, 3'b010, MB + 32'h10, 0); chk("eaddr_rst", Rd_mem_data, 32'h0);

    // Test 1: load lanes and extension
    op(0, 1, 3'b010, 32'h10, 32'h8000_80FF);
    op(1, 0, 3'b000, 32'h10, 0); chk("lb_10", Rd_mem_data, 32'hFFFF_FFFF);
    op(1, 0, 3'b100, 32'h10, 0); chk("lbu_10", Rd_mem_data, 32'h0000_00FF);
    op(1, 0, 3'b001, 32'h12, 0); chk("lh_12", Rd_mem_data, 32'hFFFF_8000);
    op(1, 0, 3'b101, 32'h12, 0); chk("lhu_12", Rd_mem_data, 32'h0000_8000);
    op(1, 0, 3'b010, 32'h10, 0); chk("lw_10", Rd_mem_data, 32'h8000_80FF);
    op(1, 0, 3'b000, 32'h13, 0); chk("lb_13", Rd_mem_data, 32'hFFFF_FF80);
    op(1, 0, 3'b011, 32'h10, 0); chk("undef_as_word", Rd_mem_data, 32'h8000_80FF);

    // Test 2: byte store merge, read-before-write
    op(0, 1, 3'b010, 32'h20, 32'h1122_3344);
    op(0, 1, 3'b000, 32'h21, 32'h0000_00AB);
    op(1, 0, 3'b010, 32'h20, 0); chk("sb_merge", Rd_mem_data, 32'h1122_AB44);
    op(0, 1, 3'b010, 32'h20, 32'h1122_3344);
    op(1, 1, 3'b010, 32'h20, 32'h1122_AB44); chk("rw_prewrite", Rd_mem_data, 32'h1122_3344);
    op(1, 0, 3'b010, 32'h20, 0); chk("rw_postwrite", Rd_mem_data, 32'h1122_AB44);

    // Test 3: errors
    op(0, 1, 3'b010, 32'h0, 32'hCAFE_BABE);
    op(0, 1, 3'b001, 32'h3, 32'h0000_FFFF);
    op(1, 0, 3'b010, 32'h0, 0); chk("mis_no_store", Rd_mem_data, 32'hCAFE_BABE);
    chk("mis_mem_err", {31'b0, mem_err}, 32'h1);
    op(1, 0, 3'b010, MB + 32'h0C, 0); chk("est_mis", Rd_mem_data, 32'h1);
    op(1, 0, 3'b010, MB + 32'h10, 0); chk("eaddr_3", Rd_mem_data, 32'h3);
    op(1, 0, 3'b001, 32'h11, 0); chk("lh_mis_zero", Rd_mem_data, 32'h0);
    op(1, 0, 3'b010, 32'h401, 0); chk("oor_zero", Rd_mem_data, 32'h0);
    op(1, 0, 3'b010, MB + 32'h0C, 0); chk("est_both", Rd_mem_data, 32'h3);
    op(1, 0, 3'b010, MB + 32'h10, 0); chk("eaddr_kept", Rd_mem_data, 32'h3);
    op(1, 0, 3'b000, MB + 32'h00, 0); chk("mmio_byte_zero", Rd_mem_data, 32'h0);
    op(0, 1, 3'b010, MB + 32'h0C, 32'h3);
    op(1, 0, 3'b010, MB + 32'h0C, 0); chk("est_clr", Rd_mem_data, 32'h0);
    chk("clr_mem_err", {31'b0, mem_err}, 32'h0);
    op(1, 0, 3'b010, MB + 32'h08, 0); chk("scnt_6", Rd_mem_data, 32'd6);
    op(1, 0, 3'b010, 32'h400, 0);
    op(1, 0, 3'b010, MB + 32'h0C, 0); chk("est_oor", Rd_mem_data, 32'h2);
    op(1, 0, 3'b010, MB + 32'h10, 0); chk("eaddr_400", Rd_mem_data, 32'h400);
    op(0, 1, 3'b010, MB + 32'h04, 32'h1234);
    op(1, 0, 3'b010, MB + 32'h20, 0); chk("mmio_other", Rd_mem_data, 32'h0);

    // Test 4: CYCLE wrap
    @(posedge clk); #1;
    force dut.cycle_q = 32'hFFFF_FFFF;
    m_cycle = 32'hFFFF_FFFF;
    R_en = 1'b1; W_en = 1'b0; RW_type = 3'b010; ram_addr = MB + 32'h04;
    @(negedge clk); chk("cycle_forced", Rd_mem_data, 32'hFFFF_FFFF);
    release dut.cycle_q;
    op(1, 0, 3'b010, MB + 32'h04, 0); chk("cycle_wrap", Rd_mem_data, 32'h0);

    // Test 5: GPIO and reset mid-store
    op(0, 1, 3'b010, MB + 32'h00, 32'h0000_01A5);
    op(1, 0, 3'b010, MB + 32'h00, 0); chk("gpio_rd", Rd_mem_data, 32'h0000_00A5);
    chk("gpio_out", {24'b0, gpio_out}, 32'hA5);
    op(0, 1, 3'b010, 32'h40, 32'h1234_5678);
    @(posedge clk); #1;
    R_en = 1'b0; W_en = 1'b1; RW_type = 3'b010; ram_addr = 32'h40; Wr_mem_data = 32'hDEAD_BEEF;
    #2 rst_n = 1'b0;
    #1 chk("rst_gpio_async", {24'b0, gpio_out}, 32'h0);
    chk("rst_err_async", {31'b0, mem_err}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; W_en = 1'b0;
    op(1, 0, 3'b010, 32'h40, 0); chk("rst_store_dropped", Rd_mem_data, 32'h1234_5678);
    op(1, 0, 3'b010, MB + 32'h08, 0); chk("rst_scnt", Rd_mem_data, 32'h0);
    op(0, 0, 3'b010, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
